wishbone_vga_fill_master: RTL

- Wishbone classic initiator that fills a range of VGA framebuffer words with a constant pattern.
- It issues single-word write cycles to the VGA controller's Wishbone slave port. Write-only; no read path.
- Sits between a CPU-side command register/CSR and the VGA controller, off-loading clear-screen and rectangle-line fills from the core.
- Processes one command at a time; cyc is held for the whole burst.

---
 rtl/wb_fill_pkg.sv | 21 ++
 rtl/wishbone_vga_fill_master.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/wb_fill_pkg.sv
// Shared types and default widths for the Wishbone VGA fill master.
package wb_fill_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LEN_W  = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } fill_state_e;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_LEN_W-1:0]  len;
    logic [DEF_DATA_W-1:0] data;
    logic [3:0]            sel;
  } fill_cmd_t;

endpackage

// File: rtl/wishbone_vga_fill_master.sv
// Wishbone classic write-only initiator that fills a framebuffer range with a constant word.
// Optional ack timeout abort enabled by defining WB_FILL_MASTER_TIMEOUT_EN.
import wb_fill_pkg::*;

module wishbone_vga_fill_master #(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int LEN_W          = DEF_LEN_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  input  logic [3:0]        cmd_sel_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [3:0]        wb_sel_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic              wb_ack_i
);

  if (TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  fill_state_e       state_q, state_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [3:0]        sel_q, sel_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              cyc_q, cyc_d;
  logic              timeout;

`ifdef WB_FILL_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;

  // Counts stalled strobe cycles of the current word; any ack restarts it.
  always_comb begin
    to_cnt_d = '0;
    timeout  = 1'b0;
    if (state_q == WRITE && !wb_ack_i) begin
      if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) timeout = 1'b1;
      else to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign err_d = timeout;
  assign err_o = err_q;
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    rem_d   = rem_q;
    cyc_d   = cyc_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          adr_d = cmd_addr_i;
          dat_d = cmd_data_i;
          sel_d = cmd_sel_i;
          rem_d = cmd_len_i;
          if (cmd_len_i == '0) begin
            state_d = DONE;
          end else begin
            state_d = WRITE;
            cyc_d   = 1'b1;
          end
        end
      end
      WRITE: begin
        if (wb_ack_i) begin
          if (rem_q == LEN_W'(1)) begin
            cyc_d   = 1'b0;
            state_d = DONE;
          end else begin
            rem_d = rem_q - LEN_W'(1);
            adr_d = adr_q + ADDR_W'(1);
          end
        end else if (timeout) begin
          cyc_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      rem_q   <= '0;
      cyc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      rem_q   <= rem_d;
      cyc_q   <= cyc_d;
    end
  end

  // Strobe stays asserted for the whole burst, so it shares the cycle flop.
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = cyc_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = sel_q;
  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q == WRITE);
  assign done_o      = (state_q == DONE);

endmodule
